mod_silencer: RTL
=================

# mod_silencer

Per-transducer slew-rate limiter between the modulation stage and the PWM stage. Each frame, the modulation stage streams `DEPTH` beats of 16-bit modulated intensity and 8-bit phase. This block holds the last emitted value for every transducer and moves it toward the new target by at most a programmed step per frame. The phase step takes the shortest path around the 256-count circle. The output is a stream in the same order with a fixed 2-cycle latency.

## Interface
- `DEPTH`, 249: transducers per frame; size of the state memory.
- `CLK` in 1: system clock (20.48 MHz domain).
- `RST_N` in 1: asynchronous, active-low reset.
- `UPDATE_RATE_INTENSITY` in 16: maximum intensity change per frame, unsigned.
- `UPDATE_RATE_PHASE` in 8: maximum phase change per frame, unsigned; values ≥128 mean the phase is never limited.
- `DIN_VALID` in 1: input beat qualifier; one beat per transducer, contiguous within a frame.
- `INTENSITY_IN` in 16: target intensity (the modulation stage's `INTENSITY_OUT`).
- `PHASE_IN` in 8: target phase.
- `DOUT_VALID` out 1: output beat qualifier.
- `INTENSITY_OUT` out 16: slew-limited intensity.
- `PHASE_OUT` out 8: slew-limited phase.
- `DEBUG_IDX` out 8: transducer index of the current output beat.

## Operation
- **Index counter `idx`:**
  - Cleared while `DIN_VALID`=0.
  - Increments on each valid beat.
  - Wraps from `DEPTH-1` to 0, so an over-long burst starts a new frame.
  - A truncated burst updates only the entries it delivered; the next burst restarts at index 0.
- **Rate sampling:** both rates are latched on the beat with `idx`=0 and held for the whole frame. Rate changes mid-frame take effect at the next frame.
- **State memory:** `DEPTH` × 24 bits, holding `cur_int[15:0]` and `cur_ph[7:0]`. It is read and written only at index `idx`, and each entry is written back with the emitted value on every beat.
- **Intensity update:**
  - d = target − cur, computed as a 17-bit signed value.
  - If |d| ≤ rate, next = target.
  - Otherwise next = cur + rate when d>0, or cur − rate when d<0.
  - No overflow is possible, because next lies between cur and target.
- **Phase update:**
  - d = (target − cur) mod 256, interpreted as 8-bit two's complement.
  - 0x80 (distance 128) is treated as positive and moves upward.
  - If |d| ≤ rate, next = target.
  - Otherwise next = (cur ± rate) mod 256, with the sign of d.
- **Rate 0:** the value holds (frozen), unless d=0.
- **Bypass:** intensity rate 0xFFFF or phase rate ≥128 gives next = target on every beat.
- **Reset:**
  - All state entries, `idx`, latched rates, pipeline registers and outputs go to 0.
  - `RST_N` asserted mid-frame aborts the frame; no partial outputs appear after release.
  - The first frame after reset slews from 0.

## Timing
- **Pipeline**, where beat k is sampled at edge t:
  - Stage 1 (edge t): registers target, idx and the state read.
  - Stage 2 (edge t+1): computes the clamp and writes back `next` at idx.
  - The output register loads at edge t+2.
- **Latency and throughput:**
  - `DOUT_VALID` follows `DIN_VALID` delayed by exactly 2 cycles, beat for beat, order preserved, with no bubbles.
  - Full rate: 1 beat/cycle, back-to-back frames with zero gap allowed.
- **Read-after-write:** not possible within a frame, because indices differ. Back-to-back frames separated by 0 idle cycles where `DEPTH`≤2 must forward the in-flight write; for `DEPTH`≥3 no hazard exists.
- **Output registers:**
  - All outputs are registered.
  - `INTENSITY_OUT` and `PHASE_OUT` hold their last value while `DOUT_VALID`=0.
  - All outputs reset to 0.

## Test plan
- **Reset:** hold `RST_N`=0 with `DIN_VALID` toggling → all outputs 0 and `DOUT_VALID`=0; after release, the first frame with target 0 outputs 0.
- **Intensity step:** rate 100, all targets 1000 for 12 frames → per frame every transducer outputs 100, 200, …, 1000, then 1000 steady; then targets 0 with rate 300 → 700, 400, 100, 0.
- **Phase wrap:** cur 250, target 4, step 3 → 253, 0, 3, 4. Also cur 0, target 128, step 10 → 10 (tie goes upward). Also cur 10, target 200, step 20 → 246.
- **Bypass and latency:**
  - Rates 0xFFFF/0x80, `DEPTH` random beats → outputs equal the inputs of the same frame.
  - `DOUT_VALID` is exactly 2 cycles after `DIN_VALID` with identical length.
  - `DEBUG_IDX` runs 0…248.
- **Frame boundaries:**
  - A burst of 100 beats, then idle, then a full frame → entries 100…248 unchanged by the short burst.
  - A burst of 250 beats → the 250th beat is treated as index 0.
  - A rate change at mid-frame beat 120 → takes effect only from the next frame.
- **Reset mid-frame:** assert `RST_N` at beat 60 of a slewing frame → `DOUT_VALID` drops immediately; the next frame slews from 0 for all entries.

Source files
------------

// File: rtl/mod_silencer.sv
// ============================================================================
// Module   : mod_silencer
// Purpose  : Per-transducer slew-rate limiter for intensity and phase.
//            Keeps the last emitted value of every transducer and moves it
//            toward the new target by at most a programmed step per frame.
//            Phase steps take the shortest path around the 256-count circle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_silencer #(
  parameter int DEPTH = 249
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] UPDATE_RATE_INTENSITY,
  input  logic [7:0]  UPDATE_RATE_PHASE,
  input  logic        DIN_VALID,
  input  logic [15:0] INTENSITY_IN,
  input  logic [7:0]  PHASE_IN,
  output logic        DOUT_VALID,
  output logic [15:0] INTENSITY_OUT,
  output logic [7:0]  PHASE_OUT,
  output logic [7:0]  DEBUG_IDX
);

  localparam int          IDX_W    = $clog2(DEPTH);
  localparam logic [7:0]  LAST_IDX = 8'(DEPTH - 1);

  // Frame index and per-frame rates
  logic [7:0]  idx_q, idx_d;
  logic [15:0] rate_int_q, rate_int_d;
  logic [7:0]  rate_ph_q, rate_ph_d;

  // Stage 1: target, index and current state
  logic        s1_valid_q, s1_valid_d;
  logic [7:0]  s1_idx_q, s1_idx_d;
  logic [15:0] s1_tgt_int_q, s1_tgt_int_d;
  logic [7:0]  s1_tgt_ph_q, s1_tgt_ph_d;
  logic [15:0] s1_cur_int_q, s1_cur_int_d;
  logic [7:0]  s1_cur_ph_q, s1_cur_ph_d;

  // Stage 2: clamped result
  logic        s2_valid_q, s2_valid_d;
  logic [7:0]  s2_idx_q, s2_idx_d;
  logic [15:0] s2_int_q, s2_int_d;
  logic [7:0]  s2_ph_q, s2_ph_d;

  // Output registers
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_idx_q, out_idx_d;
  logic [15:0] out_int_q, out_int_d;
  logic [7:0]  out_ph_q, out_ph_d;

  // State memory: {cur_int, cur_ph} per transducer
  logic [23:0] mem_q [DEPTH];
  logic [23:0] rd_data;

  // Clamp datapath
  logic [16:0] d_int;
  logic [16:0] mag_int;
  logic [7:0]  d_ph;
  logic        ph_up;
  logic [8:0]  mag_ph;
  logic [15:0] nxt_int;
  logic [7:0]  nxt_ph;

  // Slew clamp on the stage-1 beat: move by at most one step, or snap to target
  always_comb begin
    d_int   = {1'b0, s1_tgt_int_q} - {1'b0, s1_cur_int_q};
    mag_int = d_int[16] ? (~d_int + 17'd1) : d_int;
    nxt_int = s1_tgt_int_q;
    if (mag_int > {1'b0, rate_int_q}) begin
      nxt_int = d_int[16] ? (s1_cur_int_q - rate_int_q) : (s1_cur_int_q + rate_int_q);
    end

    // A half-circle distance (0x80) is resolved upward
    d_ph   = s1_tgt_ph_q - s1_cur_ph_q;
    ph_up  = !d_ph[7] || (d_ph == 8'h80);
    mag_ph = ph_up ? {1'b0, d_ph} : {1'b0, (~d_ph + 8'd1)};
    nxt_ph = s1_tgt_ph_q;
    if (!rate_ph_q[7] && (mag_ph > {1'b0, rate_ph_q})) begin
      nxt_ph = ph_up ? (s1_cur_ph_q + rate_ph_q) : (s1_cur_ph_q - rate_ph_q);
    end
  end

  // State read; forwards the in-flight write when the same entry is re-read
  always_comb begin
    rd_data = mem_q[idx_q[IDX_W-1:0]];
    if (s1_valid_q && (s1_idx_q == idx_q)) begin
      rd_data = {nxt_int, nxt_ph};
    end
  end

  // Next-state logic for index, rates and pipeline stages
  always_comb begin
    idx_d        = 8'd0;
    rate_int_d   = rate_int_q;
    rate_ph_d    = rate_ph_q;
    s1_valid_d   = DIN_VALID;
    s1_idx_d     = s1_idx_q;
    s1_tgt_int_d = s1_tgt_int_q;
    s1_tgt_ph_d  = s1_tgt_ph_q;
    s1_cur_int_d = s1_cur_int_q;
    s1_cur_ph_d  = s1_cur_ph_q;
    s2_valid_d   = s1_valid_q;
    s2_idx_d     = s2_idx_q;
    s2_int_d     = s2_int_q;
    s2_ph_d      = s2_ph_q;
    out_valid_d  = s2_valid_q;
    out_idx_d    = out_idx_q;
    out_int_d    = out_int_q;
    out_ph_d     = out_ph_q;

    if (DIN_VALID) begin
      idx_d        = (idx_q == LAST_IDX) ? 8'd0 : idx_q + 8'd1;
      s1_idx_d     = idx_q;
      s1_tgt_int_d = INTENSITY_IN;
      s1_tgt_ph_d  = PHASE_IN;
      s1_cur_int_d = rd_data[23:8];
      s1_cur_ph_d  = rd_data[7:0];
      if (idx_q == 8'd0) begin
        rate_int_d = UPDATE_RATE_INTENSITY;
        rate_ph_d  = UPDATE_RATE_PHASE;
      end
    end

    if (s1_valid_q) begin
      s2_idx_d = s1_idx_q;
      s2_int_d = nxt_int;
      s2_ph_d  = nxt_ph;
    end

    if (s2_valid_q) begin
      out_idx_d = s2_idx_q;
      out_int_d = s2_int_q;
      out_ph_d  = s2_ph_q;
    end
  end

  // Pipeline, index and rate registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idx_q        <= '0;
      rate_int_q   <= '0;
      rate_ph_q    <= '0;
      s1_valid_q   <= 1'b0;
      s1_idx_q     <= '0;
      s1_tgt_int_q <= '0;
      s1_tgt_ph_q  <= '0;
      s1_cur_int_q <= '0;
      s1_cur_ph_q  <= '0;
      s2_valid_q   <= 1'b0;
      s2_idx_q     <= '0;
      s2_int_q     <= '0;
      s2_ph_q      <= '0;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_int_q    <= '0;
      out_ph_q     <= '0;
    end else begin
      idx_q        <= idx_d;
      rate_int_q   <= rate_int_d;
      rate_ph_q    <= rate_ph_d;
      s1_valid_q   <= s1_valid_d;
      s1_idx_q     <= s1_idx_d;
      s1_tgt_int_q <= s1_tgt_int_d;
      s1_tgt_ph_q  <= s1_tgt_ph_d;
      s1_cur_int_q <= s1_cur_int_d;
      s1_cur_ph_q  <= s1_cur_ph_d;
      s2_valid_q   <= s2_valid_d;
      s2_idx_q     <= s2_idx_d;
      s2_int_q     <= s2_int_d;
      s2_ph_q      <= s2_ph_d;
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      out_int_q    <= out_int_d;
      out_ph_q     <= out_ph_d;
    end
  end

  // State memory write-back of the emitted value on every stage-1 beat
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (s1_valid_q) begin
      mem_q[s1_idx_q[IDX_W-1:0]] <= {nxt_int, nxt_ph};
    end
  end

  assign DOUT_VALID    = out_valid_q;
  assign DEBUG_IDX     = out_idx_q;
  assign INTENSITY_OUT = out_int_q;
  assign PHASE_OUT     = out_ph_q;

endmodule

`default_nettype wire
